// File: rtl/vram_host_port_if.sv
// Bus bundle between the host/videocard side and the VRAM host port.
interface vram_host_port_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned CNT_WIDTH = 32
);
  logic [WIDTH-1:0]     vc_address;
  logic [WIDTH-1:0]     vc_data_out;
  logic                 vc_wren;
  logic [WIDTH-1:0]     vc_data_in;
  logic                 interrupt_start;
  logic                 interrupt_finish;
  logic [ADDR_BITS-1:0] host_addr;
  logic [WIDTH-1:0]     host_wdata;
  logic                 host_we;
  logic                 host_re;
  logic [WIDTH-1:0]     host_rdata;
  logic                 host_rvalid;
  logic                 host_launch;
  logic                 host_ack;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [CNT_WIDTH-1:0] run_cycles;

  // Driver side: host and videocard stimulus.
  modport master (
    output vc_address, vc_data_out, vc_wren, interrupt_finish,
    output host_addr, host_wdata, host_we, host_re, host_launch, host_ack,
    input  vc_data_in, interrupt_start, host_rdata, host_rvalid,
    input  busy, done, error, run_cycles
  );

  // Responder side: the VRAM host port itself.
  modport slave (
    input  vc_address, vc_data_out, vc_wren, interrupt_finish,
    input  host_addr, host_wdata, host_we, host_re, host_launch, host_ack,
    output vc_data_in, interrupt_start, host_rdata, host_rvalid,
    output busy, done, error, run_cycles
  );
endinterface

// File: rtl/vram_host_port.sv
// Shared word RAM with a host port and a videocard port, plus the run launcher.
// The videocard owns the RAM in START/RUN; the host owns it otherwise.
module vram_host_port #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned START_PULSE = 2,
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input logic              clk,
  input logic              reset,
  vram_host_port_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned PW    = (START_PULSE > 1) ? $clog2(START_PULSE) : 1;
  localparam logic [PW-1:0]        PULSE_LAST = PW'(START_PULSE - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DONE, S_ERR} state_t;

  state_t               state_q;
  logic [PW-1:0]        pulse_q;
  logic [CNT_WIDTH-1:0] run_cycles_q;
  logic                 start_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;
  logic [WIDTH-1:0]     vc_data_in_q;
  logic [WIDTH-1:0]     host_rdata_q;
  logic                 host_rvalid_q;

  logic [WIDTH-1:0]     mem [DEPTH];

  logic                 vc_own_c;
  logic [ADDR_BITS-1:0] vc_addr_c;
  logic                 mem_we_c;
  logic [ADDR_BITS-1:0] mem_waddr_c;
  logic [WIDTH-1:0]     mem_wdata_c;
  logic                 unused_vc_addr_hi;

  assign vc_own_c          = (state_q == S_START) || (state_q == S_RUN);
  assign vc_addr_c         = bus.vc_address[ADDR_BITS-1:0];
  assign unused_vc_addr_hi = ^bus.vc_address[WIDTH-1:ADDR_BITS];

  // Single write port, muxed by current owner; no writes while reset is held.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = bus.host_addr;
    mem_wdata_c = bus.host_wdata;
    if (vc_own_c) begin
      mem_we_c    = bus.vc_wren;
      mem_waddr_c = vc_addr_c;
      mem_wdata_c = bus.vc_data_out;
    end else begin
      mem_we_c    = bus.host_we;
    end
    if (reset) mem_we_c = 1'b0;
  end

  // RAM array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  // Registered read-first data for whichever port owns the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vc_data_in_q  <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      host_rvalid_q <= !vc_own_c && bus.host_re;
      if (vc_own_c) begin
        vc_data_in_q <= mem[vc_addr_c];
      end else if (bus.host_re) begin
        host_rdata_q <= mem[bus.host_addr];
      end
    end
  end

  // Launch / run / completion sequencer with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pulse_q      <= '0;
      run_cycles_q <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.host_launch) begin
            state_q      <= S_START;
            start_q      <= 1'b1;
            busy_q       <= 1'b1;
            pulse_q      <= '0;
            run_cycles_q <= '0;
          end
        end
        S_START: begin
          if (pulse_q == PULSE_LAST) begin
            state_q <= S_RUN;
            start_q <= 1'b0;
          end else begin
            pulse_q <= pulse_q + 1'b1;
          end
        end
        S_RUN: begin
          if (run_cycles_q != '1) run_cycles_q <= run_cycles_q + 1'b1;
          if (bus.interrupt_finish) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if ((TIMEOUT != 0) && (run_cycles_q == TO_LAST)) begin
            state_q <= S_ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          if (bus.host_ack) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          error_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vc_data_in      = vc_data_in_q;
  assign bus.interrupt_start = start_q;
  assign bus.host_rdata      = host_rdata_q;
  assign bus.host_rvalid     = host_rvalid_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.error           = error_q;
  assign bus.run_cycles      = run_cycles_q;

endmodule

// File: tb/tb_vram_host_port.sv
// Self-checking bench for vram_host_port: directed scenarios plus random traffic
// against a behavioural model of the shared RAM and the launch/run sequence.
module tb_vram_host_port;

  localparam int WIDTH       = 32;
  localparam int ADDR_BITS   = 10;
  localparam int START_PULSE = 2;
  localparam int TIMEOUT     = 20;
  localparam int CNT_WIDTH   = 32;

  logic clk = 1'b0;
  logic reset;

  vram_host_port_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .CNT_WIDTH(CNT_WIDTH)) b ();

  vram_host_port #(
    .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .START_PULSE(START_PULSE),
    .TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [31:0] ram [int];
  int          start_left;
  bit          running;
  longint      cyc;
  bit          e_done, e_err, e_rv;
  logic [31:0] e_vc, e_hr;
  bit          e_vck, e_hrk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    start_left = 0;
    running    = 0;
    cyc        = 0;
    e_done     = 0;
    e_err      = 0;
    e_rv       = 0;
    e_vc       = '0;
    e_hr       = '0;
    e_vck      = 1;
    e_hrk      = 1;
  endtask

  // Advance the model across one rising edge using the inputs now on the bus.
  task automatic model_step();
    bit own;
    bit idle;
    int a;
    if (reset) begin
      model_reset();
    end else begin
      own  = (start_left > 0) || running;
      idle = !own && !e_done && !e_err;
      if (own) begin
        a = int'(b.vc_address % (1 << ADDR_BITS));
        e_vck = ram.exists(a);
        if (e_vck) e_vc = ram[a];
        if (b.vc_wren) ram[a] = b.vc_data_out;
        e_rv = 0;
      end else begin
        e_rv = b.host_re;
        if (b.host_re) begin
          a = int'(b.host_addr);
          e_hrk = ram.exists(a);
          if (e_hrk) e_hr = ram[a];
        end
        if (b.host_we) ram[int'(b.host_addr)] = b.host_wdata;
      end
      if (idle) begin
        if (b.host_launch) begin
          start_left = START_PULSE;
          cyc = 0;
        end
      end else if (start_left > 0) begin
        start_left--;
        if (start_left == 0) running = 1;
      end else if (running) begin
        if (cyc < 64'hFFFF_FFFF) cyc++;
        if (b.interrupt_finish) begin
          running = 0;
          e_done  = 1;
        end else if (TIMEOUT != 0 && cyc == TIMEOUT) begin
          running = 0;
          e_err   = 1;
        end
      end else if (b.host_ack) begin
        e_done = 0;
        e_err  = 0;
      end
    end
  endtask

  task automatic compare();
    chk("interrupt_start", 64'(b.interrupt_start), 64'(start_left > 0));
    chk("busy",            64'(b.busy),            64'((start_left > 0) || running));
    chk("done",            64'(b.done),            64'(e_done));
    chk("error",           64'(b.error),           64'(e_err));
    chk("host_rvalid",     64'(b.host_rvalid),     64'(e_rv));
    chk("run_cycles",      64'(b.run_cycles),      64'(cyc[31:0]));
    if (e_vck) chk("vc_data_in", 64'(b.vc_data_in), 64'(e_vc));
    if (e_hrk) chk("host_rdata", 64'(b.host_rdata), 64'(e_hr));
  endtask

  // One clock: model consumes the driven inputs, then outputs are checked mid-cycle.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clr();
    b.vc_address       = '0;
    b.vc_data_out      = '0;
    b.vc_wren          = 1'b0;
    b.interrupt_finish = 1'b0;
    b.host_addr        = '0;
    b.host_wdata       = '0;
    b.host_we          = 1'b0;
    b.host_re          = 1'b0;
    b.host_launch      = 1'b0;
    b.host_ack         = 1'b0;
  endtask

  // Launch from IDLE and stop on the first RUN cycle; reports START pulse length.
  task automatic go_run(output int pulses);
    bit reached;
    pulses  = 0;
    reached = 0;
    clr();
    b.host_launch = 1'b1;
    tick();
    b.host_launch = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (b.interrupt_start) pulses++;
      if (b.busy && !b.interrupt_start) begin
        reached = 1;
        break;
      end
      tick();
    end
    chk("reach_run", 64'(reached), 64'd1);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_vc_data_in"},  64'(b.vc_data_in),      64'd0);
    chk({tag, "_int_start"},   64'(b.interrupt_start), 64'd0);
    chk({tag, "_host_rdata"},  64'(b.host_rdata),      64'd0);
    chk({tag, "_host_rvalid"}, 64'(b.host_rvalid),     64'd0);
    chk({tag, "_busy"},        64'(b.busy),            64'd0);
    chk({tag, "_done"},        64'(b.done),            64'd0);
    chk({tag, "_error"},       64'(b.error),           64'd0);
    chk({tag, "_run_cycles"},  64'(b.run_cycles),      64'd0);
  endtask

  initial begin
    int pulses;
    int n;
    reset = 1'b1;
    clr();
    model_reset();
    tick();
    tick();
    check_all_zero("por");
    reset = 1'b0;

    // Host write then read in IDLE
    b.host_we = 1'b1; b.host_addr = 10'd5; b.host_wdata = 32'hDEAD_BEEF;
    tick();
    clr();
    b.host_re = 1'b1; b.host_addr = 10'd5;
    tick();
    clr();
    chk("host_rd_valid", 64'(b.host_rvalid), 64'd1);
    chk("host_rd_data",  64'(b.host_rdata),  64'hDEAD_BEEF);
    tick();
    chk("host_rvalid_pulse", 64'(b.host_rvalid), 64'd0);
    chk("host_rdata_hold",   64'(b.host_rdata),  64'hDEAD_BEEF);

    // Launch, finish on the 10th RUN cycle
    go_run(pulses);
    chk("start_pulse_len", 64'(pulses), 64'd2);
    for (int i = 0; i < 10; i++) begin
      b.interrupt_finish = (i == 9);
      tick();
    end
    clr();
    chk("fin_done",       64'(b.done),       64'd1);
    chk("fin_busy",       64'(b.busy),       64'd0);
    chk("fin_run_cycles", 64'(b.run_cycles), 64'd10);
    b.host_ack = 1'b1;
    tick();
    clr();
    chk("ack_done",       64'(b.done),       64'd0);
    chk("ack_run_cycles", 64'(b.run_cycles), 64'd10);

    // Videocard access in RUN, host access dropped
    go_run(pulses);
    b.vc_wren = 1'b1; b.vc_address = 32'h405; b.vc_data_out = 32'h1234_5678;
    tick();
    clr();
    b.host_we = 1'b1; b.host_re = 1'b1; b.host_addr = 10'd5; b.host_wdata = 32'h0000_0BAD;
    tick();
    clr();
    chk("run_no_rvalid", 64'(b.host_rvalid), 64'd0);
    b.vc_address = 32'd5;
    tick();
    clr();
    chk("vc_readback", 64'(b.vc_data_in), 64'h1234_5678);
    b.interrupt_finish = 1'b1;
    tick();
    clr();
    b.host_ack = 1'b1;
    tick();
    clr();
    b.host_re = 1'b1; b.host_addr = 10'd5;
    tick();
    clr();
    chk("host_sees_vc_write", 64'(b.host_rdata), 64'h1234_5678);

    // Timeout
    go_run(pulses);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (b.error) break;
      tick();
      n++;
    end
    chk("to_error",      64'(b.error),      64'd1);
    chk("to_cycles",     64'(n),            64'd20);
    chk("to_run_cycles", 64'(b.run_cycles), 64'd20);
    b.host_launch = 1'b1;
    tick();
    clr();
    chk("to_launch_ign_busy", 64'(b.busy),  64'd0);
    chk("to_launch_ign_err",  64'(b.error), 64'd1);
    b.host_ack = 1'b1;
    tick();
    clr();
    chk("to_ack_error", 64'(b.error), 64'd0);

    // Finish and timeout on the same cycle
    go_run(pulses);
    for (int i = 0; i < 20; i++) begin
      b.interrupt_finish = (i == 19);
      tick();
    end
    clr();
    chk("tie_done",       64'(b.done),       64'd1);
    chk("tie_error",      64'(b.error),      64'd0);
    chk("tie_run_cycles", 64'(b.run_cycles), 64'd20);
    b.host_ack = 1'b1;
    tick();
    clr();

    // Asynchronous reset in the middle of RUN
    go_run(pulses);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    reset = 1'b0;
    clr();
    b.host_re = 1'b1; b.host_addr = 10'd5;
    tick();
    clr();
    chk("rst_ram_keep_valid", 64'(b.host_rvalid), 64'd1);
    chk("rst_ram_keep_data",  64'(b.host_rdata),  64'h1234_5678);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset              = ($urandom_range(0, 399) == 0);
      b.vc_address       = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
      b.vc_data_out      = $urandom();
      b.vc_wren          = ($urandom_range(0, 9) < 3);
      b.interrupt_finish = ($urandom_range(0, 11) == 0);
      b.host_addr        = 10'($urandom_range(0, 15));
      b.host_wdata       = $urandom();
      b.host_we          = ($urandom_range(0, 9) < 3);
      b.host_re          = ($urandom_range(0, 9) < 4);
      b.host_launch      = ($urandom_range(0, 9) < 3);
      b.host_ack         = ($urandom_range(0, 9) < 2);
      tick();
    end
    reset = 1'b0;
    clr();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
